id_fsm: RTL and testbench

//   Character-stream recogniser for "identifier-with-numeric-suffix" tokens.
//   - Consumes one 8-bit ASCII char per clock.
//   - out is asserted while the chars accepted so far end in a run of one or

---
 rtl/id_fsm.sv | 84 ++++++++
 tb/tb_id_fsm.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/id_fsm.sv
// id_fsm: recognises letter-run + digit-run token suffixes in a byte stream.
// Optional macro ID_UNDERSCORE_EN: when defined, '_' (0x5F) counts as a letter.
module id_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] char,
   output logic       out
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ALPHA = 2'b01,
      S_NUM   = 2'b10,
      S_BAD   = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      C_OTHER  = 2'b00,
      C_LETTER = 2'b01,
      C_DIGIT  = 2'b10
   } class_e;

   state_e state_q;
   state_e state_d;
   class_e cls;

   logic is_upper;
   logic is_lower;
   logic is_digit;
   logic is_under;

   assign is_upper = (char >= 8'h41) && (char <= 8'h5A);
   assign is_lower = (char >= 8'h61) && (char <= 8'h7A);
   assign is_digit = (char >= 8'h30) && (char <= 8'h39);

`ifdef ID_UNDERSCORE_EN
   assign is_under = (char == 8'h5F);
`else
   assign is_under = 1'b0;
`endif

   // Classify the incoming character; the three classes are disjoint.
   always_comb begin
      cls = C_OTHER;
      unique case (1'b1)
         is_upper, is_lower, is_under: cls = C_LETTER;
         is_digit:                     cls = C_DIGIT;
         default:                      cls = C_OTHER;
      endcase
   end

   // State register; reset discards any token in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: letters (re)start a run, digits extend one, others clear.
   always_comb begin
      state_d = S_IDLE;
      unique case (state_q)
         S_IDLE: begin
            if (cls == C_LETTER) state_d = S_ALPHA;
            else                 state_d = S_IDLE;
         end
         S_ALPHA, S_NUM: begin
            if (cls == C_LETTER)     state_d = S_ALPHA;
            else if (cls == C_DIGIT) state_d = S_NUM;
            else                     state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Moore output, decoded from state only.
   always_comb begin
      out = 1'b0;
      if (state_q == S_NUM) out = 1'b1;
   end

endmodule

// File: tb/tb_id_fsm.sv
// tb_id_fsm: directed-vector bench for id_fsm.
// Inputs change 1 time unit after a rising edge; out is sampled there too.
module tb_id_fsm;

   logic       clk;
   logic       reset;
   logic [7:0] char;
   logic       out;

   int vectors;
   int miscompares;

   id_fsm dut (
      .clk   (clk),
      .reset (reset),
      .char  (char),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one char, let one edge consume it, settle just after the edge.
   task automatic step(input logic [7:0] c);
      char = c;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      char  = 8'h61;
      @(posedge clk);
      @(posedge clk);
      #1;
      vectors++;
      if (out !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_hold: out=%b expected=0", out);
      end
      reset = 1'b0;
      step(8'h31);
      vectors++;
      if (out !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_first_digit: out=%b expected=0", out);
      end
   endtask

   task automatic test_basic;
      logic [7:0] seq [8];
      logic       exp [8];
      seq = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h30, 8'h31, 8'h32, 8'h33};
      exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      step(8'h20);
      for (int i = 0; i < 8; i++) begin
         step(seq[i]);
         vectors++;
         if (out !== exp[i]) begin
            miscompares++;
            $display("FAIL basic[%0d] char=%h: out=%b expected=%b",
                     i, seq[i], out, exp[i]);
         end
      end
   endtask

   task automatic test_restart;
      logic [7:0] seq [9];
      logic       exp [9];
      seq = '{8'h20, 8'h37, 8'h31, 8'h78, 8'h35, 8'h35, 8'h35, 8'h79, 8'h36};
      exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 9; i++) begin
         step(seq[i]);
         vectors++;
         if (out !== exp[i]) begin
            miscompares++;
            $display("FAIL restart[%0d] char=%h: out=%b expected=%b",
                     i, seq[i], out, exp[i]);
         end
      end
   endtask

   task automatic test_bounds;
      logic [7:0] seq [8];
      logic       exp [8];
      logic [7:0] oth [9];
      seq = '{8'h41, 8'h3A, 8'h39, 8'h5A, 8'h39, 8'h7B, 8'h40, 8'h30};
      exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         step(seq[i]);
         vectors++;
         if (out !== exp[i]) begin
            miscompares++;
            $display("FAIL bounds[%0d] char=%h: out=%b expected=%b",
                     i, seq[i], out, exp[i]);
         end
      end
      oth = '{8'h00, 8'h2F, 8'h3A, 8'h40, 8'h5B,
              8'h60, 8'h7B, 8'h80, 8'hFF};
      for (int i = 0; i < 9; i++) begin
         step(8'h7A);
         step(8'h30);
         vectors++;
         if (out !== 1'b1) begin
            miscompares++;
            $display("FAIL bounds_pre[%0d]: out=%b expected=1", i, out);
         end
         step(oth[i]);
         vectors++;
         if (out !== 1'b0) begin
            miscompares++;
            $display("FAIL bounds_other char=%h: out=%b expected=0",
                     oth[i], out);
         end
         step(8'h39);
         vectors++;
         if (out !== 1'b0) begin
            miscompares++;
            $display("FAIL bounds_after char=%h: out=%b expected=0",
                     oth[i], out);
         end
      end
   endtask

   task automatic test_reset_mid;
      step(8'h20);
      step(8'h71);
      step(8'h31);
      step(8'h32);
      vectors++;
      if (out !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_pre: out=%b expected=1", out);
      end
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if (out !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_async: out=%b expected=0", out);
      end
      char = 8'h35;
      @(posedge clk);
      #2;
      reset = 1'b0;
      step(8'h33);
      vectors++;
      if (out !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_after: out=%b expected=0", out);
      end
      step(8'h61);
      step(8'h34);
      vectors++;
      if (out !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_recover: out=%b expected=1", out);
      end
   endtask

   task automatic test_underscore;
      logic en;
`ifdef ID_UNDERSCORE_EN
      en = 1'b1;
`else
      en = 1'b0;
`endif
      step(8'h20);
      step(8'h61);
      step(8'h5F);
      step(8'h31);
      vectors++;
      if (out !== en) begin
         miscompares++;
         $display("FAIL underscore_a_1: out=%b expected=%b", out, en);
      end
      step(8'h20);
      step(8'h5F);
      step(8'h39);
      vectors++;
      if (out !== en) begin
         miscompares++;
         $display("FAIL underscore_lead: out=%b expected=%b", out, en);
      end
      step(8'h5F);
      vectors++;
      if (out !== 1'b0) begin
         miscompares++;
         $display("FAIL underscore_after_digit: out=%b expected=0", out);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      char        = 8'h00;
      test_reset();
      test_basic();
      test_restart();
      test_bounds();
      test_reset_mid();
      test_underscore();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
